// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by R,
// N integrator stages at the output rate, rescaled and saturated output.
module cic_interpolator #(
  parameter int INPUT_WIDTH   = 32,
  parameter int OUTPUT_WIDTH  = 32,
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    data_valid,
  output logic                    input_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    output_valid,
  output logic                    underrun
);

  localparam int LOG2R = $clog2(INTERPOLATION);
  localparam int W     = INPUT_WIDTH + STAGES * LOG2R;
  localparam int SHIFT = (STAGES - 1) * LOG2R;
  localparam int OW    = OUTPUT_WIDTH;
  localparam logic [LOG2R-1:0] P_LAST =
    LOG2R'(INTERPOLATION - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;
  logic [LOG2R-1:0] p, p_nxt;
  logic accept, last;

  logic signed [W-1:0] dly    [STAGES];
  logic signed [W-1:0] integ  [STAGES];
  logic signed [W-1:0] integ_nxt [STAGES];
  logic signed [W-1:0] comb_v [STAGES+1];
  logic signed [W-1:0] comb_out_reg;
  logic signed [W-1:0] inject;
  logic signed [W-1:0] shifted;
  logic [W-OW:0]       hi;
  logic [OW-1:0]       sat;

  assign last   = (p == P_LAST);
  assign accept = data_valid & input_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          p_nxt     = '0;
        end
      end
      RUN: begin
        p_nxt = p + 1'b1;
        if (last && !accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    input_ready = 1'b0;
    unique case (state)
      IDLE:    input_ready = 1'b1;
      RUN:     input_ready = last;
      default: input_ready = 1'b0;
    endcase
  end

  always_comb begin
    comb_v[0] = {{(W-INPUT_WIDTH){data_in[INPUT_WIDTH-1]}},
                 data_in};
    for (int k = 0; k < STAGES; k++)
      comb_v[k+1] = comb_v[k] - dly[k];
  end

  // Zero-stuffing: only phase 0 carries the new comb sample.
  always_comb begin
    inject = (p == '0) ? comb_out_reg : '0;
    integ_nxt[0] = integ[0] + inject;
    for (int k = 1; k < STAGES; k++)
      integ_nxt[k] = integ[k] + integ_nxt[k-1];
  end

  always_comb begin
    shifted = integ_nxt[STAGES-1] >>> SHIFT;
    hi      = shifted[W-1:OW-1];
    if ((&hi) || !(|hi))
      sat = shifted[OW-1:0];
    else if (shifted[W-1])
      sat = {1'b1, {(OW-1){1'b0}}};
    else
      sat = {1'b0, {(OW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        dly[k]   <= '0;
        integ[k] <= '0;
      end
      comb_out_reg <= '0;
      data_out     <= '0;
      output_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < STAGES; k++)
          dly[k] <= comb_v[k];
        comb_out_reg <= comb_v[STAGES];
      end
      if (state == RUN) begin
        for (int k = 0; k < STAGES; k++)
          integ[k] <= integ_nxt[k];
        data_out <= sat;
      end
      output_valid <= (state == RUN);
      underrun     <= (state == RUN) && last && !accept;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator at N=3, R=8, 32-bit samples.
// Expected values are hand-derived CIC impulse/step responses.
module tb_cic_interpolator;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        input_ready;
  logic [31:0] data_out;
  logic        output_valid;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] smp [8];
  int          nsmp;
  logic [31:0] outs [$];
  bit          vh [$];
  int          nready, nunder, nacc;

  // First 8 impulse outputs for x = 0x10000 (x*C(n+2,2) >> 6).
  logic [31:0] imp [8] = '{32'h400, 32'hC00, 32'h1800,
    32'h2800, 32'h3C00, 32'h5400, 32'h7000, 32'h9000};

  localparam logic [31:0] X = 32'h0001_0000;

  cic_interpolator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .input_ready  (input_ready),
    .data_out     (data_out),
    .output_valid (output_valid),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input int cycles);
    int idx;
    idx = 0;
    outs.delete();
    vh.delete();
    nready = 0;
    nunder = 0;
    for (int c = 0; c < cycles; c++) begin
      data_valid = (idx < nsmp);
      data_in    = (idx < nsmp) ? smp[idx] : '0;
      if (input_ready) nready++;
      if (data_valid && input_ready) idx++;
      @(posedge clk);
      #1;
      vh.push_back(output_valid);
      if (output_valid) outs.push_back(data_out);
      if (underrun) nunder++;
    end
    data_valid = 1'b0;
    nacc = idx;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (output_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", output_valid);
    end
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", data_out);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_underrun got %b want 0", underrun);
    end
    checks++;
    if (input_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", input_ready);
    end
  endtask

  task automatic test_impulse();
    longint sum;
    do_reset();
    smp  = '{X, 0, 0, 0, 0, 0, 0, 0};
    nsmp = 5;
    drive(50);
    checks++;
    if (vh[0] !== 1'b0 || vh[1] !== 1'b1) begin
      errors++;
      $display("FAIL imp_latency got %b%b want 01", vh[0], vh[1]);
    end
    checks++;
    if (outs.size() != 40) begin
      errors++;
      $display("FAIL imp_count got %0d want 40", outs.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== imp[i]) begin
        errors++;
        $display("FAIL imp_out[%0d] got %h want %h",
                 i, outs[i], imp[i]);
      end
    end
    sum = 0;
    foreach (outs[i]) sum += longint'($signed(outs[i]));
    checks++;
    if (sum != 64'h80000) begin
      errors++;
      $display("FAIL imp_sum got %h want 80000", sum);
    end
    checks++;
    if (nunder != 1) begin
      errors++;
      $display("FAIL imp_underrun got %0d want 1", nunder);
    end
  endtask

  task automatic test_step();
    int nv;
    do_reset();
    smp  = '{X, X, X, X, X, X, X, X};
    nsmp = 5;
    drive(42);
    nv = 0;
    for (int i = 1; i <= 40; i++) if (vh[i]) nv++;
    checks++;
    if (nv != 40) begin
      errors++;
      $display("FAIL step_continuous got %0d want 40", nv);
    end
    checks++;
    if (outs[23] !== X) begin
      errors++;
      $display("FAIL step_settle got %h want %h", outs[23], X);
    end
    checks++;
    if (outs[39] !== X) begin
      errors++;
      $display("FAIL step_final got %h want %h", outs[39], X);
    end
  endtask

  task automatic test_underrun();
    longint sum;
    do_reset();
    smp  = '{X, 0, 0, 0, 0, 0, 0, 0};
    nsmp = 1;
    drive(14);
    sum = 0;
    foreach (outs[i]) sum += longint'($signed(outs[i]));
    checks++;
    if (outs.size() != 8) begin
      errors++;
      $display("FAIL und_count got %0d want 8", outs.size());
    end
    checks++;
    if (nunder != 1) begin
      errors++;
      $display("FAIL und_pulse got %0d want 1", nunder);
    end
    checks++;
    if (vh[9] !== 1'b0 || data_out !== 32'h9000) begin
      errors++;
      $display("FAIL und_hold got %b/%h want 0/9000",
               vh[9], data_out);
    end
    smp  = '{0, 0, 0, 0, 0, 0, 0, 0};
    nsmp = 3;
    drive(30);
    foreach (outs[i]) sum += longint'($signed(outs[i]));
    checks++;
    if (outs[0] !== 32'hA800) begin
      errors++;
      $display("FAIL und_resume0 got %h want a800", outs[0]);
    end
    checks++;
    if (outs[7] !== 32'h7000) begin
      errors++;
      $display("FAIL und_resume7 got %h want 7000", outs[7]);
    end
    checks++;
    if (sum != 64'h80000) begin
      errors++;
      $display("FAIL und_sum got %h want 80000", sum);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    smp  = '{X, 0, 0, 0, 0, 0, 0, 0};
    nsmp = 6;
    drive(40);
    checks++;
    if (nready != 5) begin
      errors++;
      $display("FAIL bp_ready got %0d want 5", nready);
    end
    checks++;
    if (nacc != 5) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 5", nacc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== imp[i]) begin
        errors++;
        $display("FAIL bp_out[%0d] got %h want %h",
                 i, outs[i], imp[i]);
      end
    end
    checks++;
    if (outs[8] !== 32'hA800) begin
      errors++;
      $display("FAIL bp_out[8] got %h want a800", outs[8]);
    end
  endtask

  task automatic test_saturation();
    int bad;
    logic [31:0] lastv;
    do_reset();
    for (int i = 0; i < 8; i++) smp[i] = 32'h7FFF_FFFF;
    nsmp = 6;
    drive(50);
    bad = 0;
    foreach (outs[i]) if (outs[i][31]) bad++;
    lastv = outs[outs.size()-1];
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_pos_wrap got %0d want 0", bad);
    end
    checks++;
    if (lastv !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL sat_pos got %h want 7fffffff", lastv);
    end
    do_reset();
    for (int i = 0; i < 8; i++) smp[i] = 32'h8000_0000;
    drive(50);
    bad = 0;
    foreach (outs[i]) if (!outs[i][31]) bad++;
    lastv = outs[outs.size()-1];
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_neg_wrap got %0d want 0", bad);
    end
    checks++;
    if (lastv !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sat_neg got %h want 80000000", lastv);
    end
  endtask

  task automatic test_reset_midrun();
    longint sum;
    do_reset();
    smp  = '{X, 0, 0, 0, 0, 0, 0, 0};
    nsmp = 1;
    drive(5);
    checks++;
    if (output_valid !== 1'b1 || data_out !== 32'h2800) begin
      errors++;
      $display("FAIL mid_pre got %b/%h want 1/2800",
               output_valid, data_out);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b0 || data_out !== 32'h0 ||
        underrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got %b/%h/%b want 0/0/0",
               output_valid, data_out, underrun);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (input_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready got %b want 1", input_ready);
    end
    nsmp = 5;
    drive(50);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== imp[i]) begin
        errors++;
        $display("FAIL mid_out[%0d] got %h want %h",
                 i, outs[i], imp[i]);
      end
    end
    sum = 0;
    foreach (outs[i]) sum += longint'($signed(outs[i]));
    checks++;
    if (sum != 64'h80000) begin
      errors++;
      $display("FAIL mid_sum got %h want 80000", sum);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    nsmp       = 0;
    test_reset();
    test_impulse();
    test_step();
    test_underrun();
    test_back_to_back();
    test_saturation();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 32: signed two's-complement input sample width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32: signed two's-complement output sample width.
REQ-003 SHALL have parameter STAGES, default 3: number of comb stages and number of integrator stages (N), with differential delay 1.
REQ-004 SHALL have parameter INTERPOLATION, default 8: rate-change factor R, power of two, at least 2; LOG2R = log2(R).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, INPUT_WIDTH bits: low-rate input sample.
REQ-008 SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-009 SHALL have port input_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-010 SHALL have port data_out, output, OUTPUT_WIDTH bits: high-rate output sample.
REQ-011 SHALL have port output_valid, output, 1 bit: data_out is valid this cycle.
REQ-012 SHALL have port underrun, output, 1 bit: one-cycle pulse when the stream stalls for lack of input.

Function
REQ-013 SHALL accept a sample at a rising edge where data_valid=1 and input_ready=1; data_valid with input_ready=0 SHALL be ignored, and upstream holds the sample.
REQ-014 SHALL hold all internal arithmetic at W = INPUT_WIDTH + STAGES*LOG2R bits, sign-extending the input; comb and integrator sums SHALL wrap modulo 2^W.
REQ-015 SHALL run the comb chain once per accepted sample: stage k output = stage k input minus that stage's previous input; the delay registers and comb_out_reg SHALL update at the acceptance edge.
REQ-016 SHALL use states IDLE and RUN with phase counter p in 0..R-1.
REQ-017 IDLE: input_ready=1; on acceptance, go to RUN with p=0.
REQ-018 RUN: at each edge, update the integrators with inject = comb_out_reg if p=0 and 0 otherwise (zero-stuffing); then increment p.
REQ-019 RUN: input_ready=1 only when p=R-1.
REQ-020 RUN at p=R-1 with acceptance: stay in RUN, set p to 0, and load comb_out_reg.
REQ-021 RUN at p=R-1 without acceptance: go to IDLE, hold the integrators, and pulse underrun for one cycle.
REQ-022 SHALL chain the integrators within one edge: I1 <= I1 + inject, Ik <= Ik + (new I(k-1)).
REQ-023 SHALL register data_out = saturate(new IN >>> ((STAGES-1)*LOG2R)) to the OUTPUT_WIDTH signed range, clamping to max/min positive/negative.
REQ-024 SHALL assert output_valid at every RUN-edge update, making data_out visible one cycle after each integrator update.
REQ-025 SHALL have a first-output latency of 1 cycle: acceptance at edge T, first valid output after edge T+1, then R consecutive valid cycles.
REQ-026 SHALL produce continuous output_valid when an input is accepted every R cycles.
REQ-027 SHALL resume an interrupted stream, after an IDLE gap, as if it had been contiguous.
REQ-028 Net DC gain SHALL be 1: constant input x gives steady-state data_out = x.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear state to IDLE, p=0, and all comb, integrator and comb_out registers to 0.
REQ-030 rst_n=0 SHALL asynchronously clear data_out=0, output_valid=0 and underrun=0; input_ready SHALL be 1 after reset release.
REQ-031 Reset mid-stream SHALL discard all in-flight state; the first post-reset sample SHALL behave as the first sample after power-up.

Verification (defaults N=3, R=8)
REQ-032 Impulse: accept 0x00010000, then 0 at every ready slot -> first 8 outputs 0x400, 0xC00, 0x1800, 0x2800, 0x3C00, 0x5400, 0x7000, 0x9000, and the sum of all outputs = 0x80000.
REQ-033 Step: constant 0x00010000 accepted every 8 cycles -> output_valid never drops; data_out settles at 0x00010000 within 3 input periods.
REQ-034 Underrun: accept one sample, then withhold data_valid -> exactly 8 output_valid cycles, underrun pulses once, integrators hold; a later sample continues the same sequence.
REQ-035 Backpressure: data_valid held high continuously -> input_ready high 1 cycle in 8; each sample consumed exactly once.
REQ-036 Saturation: constant 0x7FFFFFFF input -> data_out clamps at 0x7FFFFFFF, never wraps negative; constant 0x80000000 input -> data_out = 0x80000000.
REQ-037 Reset mid-run: assert rst_n=0 at p=4 -> outputs and underrun clear immediately; input_ready=1 after reset release; a repeat of the impulse test reproduces the REQ-032 values.
